// File: rtl/bp_me_pkg.sv
// Memory-engine types shared by the CCE memory-message to link serialiser.
package bp_me_pkg;

  typedef enum logic {
    e_bp_inv_cfg = 1'b0
  } bp_params_e;

  typedef struct packed {
    int unsigned paddr_width;
    int unsigned cce_block_width;
    int unsigned dword_width;
    int unsigned lce_id_width;
    int unsigned lce_assoc;
  } bp_proc_param_s;

  // Processor configuration lookup
  function automatic bp_proc_param_s bp_proc_param(input bp_params_e cfg);
    bp_proc_param_s p;
    p = '0;
    if (cfg == e_bp_inv_cfg) begin
      p.paddr_width     = 40;
      p.cce_block_width = 512;
      p.dword_width     = 64;
      p.lce_id_width    = 4;
      p.lce_assoc       = 8;
    end
    return p;
  endfunction

  localparam bp_proc_param_s inv_cfg_lp = bp_proc_param(e_bp_inv_cfg);

  localparam int unsigned paddr_width_p     = inv_cfg_lp.paddr_width;
  localparam int unsigned cce_block_width_p = inv_cfg_lp.cce_block_width;
  localparam int unsigned dword_width_p     = inv_cfg_lp.dword_width;
  localparam int unsigned lce_id_width_p    = inv_cfg_lp.lce_id_width;
  localparam int unsigned lce_assoc_p       = inv_cfg_lp.lce_assoc;
  localparam int unsigned way_id_width_p    = $clog2(lce_assoc_p);

  typedef enum logic [3:0] {
    e_cce_mem_rd    = 4'b0000,
    e_cce_mem_wr    = 4'b0001,
    e_cce_mem_uc_rd = 4'b0010,
    e_cce_mem_uc_wr = 4'b0011,
    e_cce_mem_wb    = 4'b0100
  } bp_cce_mem_cmd_type_e;

  typedef enum logic [2:0] {
    e_mem_msg_size_1  = 3'b000,
    e_mem_msg_size_2  = 3'b001,
    e_mem_msg_size_4  = 3'b010,
    e_mem_msg_size_8  = 3'b011,
    e_mem_msg_size_16 = 3'b100,
    e_mem_msg_size_32 = 3'b101,
    e_mem_msg_size_64 = 3'b110
  } bp_mem_msg_size_e;

  typedef struct packed {
    logic [lce_id_width_p-1:0] lce_id;
    logic [way_id_width_p-1:0] way_id;
  } bp_cce_mem_payload_s;

  typedef struct packed {
    logic [cce_block_width_p-1:0] data;
    bp_cce_mem_payload_s          payload;
    bp_mem_msg_size_e             size;
    logic [paddr_width_p-1:0]     addr;
    bp_cce_mem_cmd_type_e         msg_type;
  } bp_cce_mem_msg_s;

  localparam int unsigned cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s);

  // Header flit sent ahead of every transaction on the link
  typedef struct packed {
    logic [dword_width_p-paddr_width_p-2:0] pad;
    logic                                   write;
    logic [paddr_width_p-1:0]               addr;
  } bp_me_link_hdr_s;

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up-counter with synchronous clear; holds at max_val_p rather than wrapping.
module bsg_counter_clear_up #(
  parameter int unsigned max_val_p = 7,
  parameter int unsigned width_p   = 3
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  localparam logic [width_p-1:0] max_lp = width_p'(max_val_p);

  logic [width_p-1:0] count_q, count_d;

  // Next count: clear wins over increment
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (up_i && (count_q != max_lp)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/bsg_serial_in_parallel_out_full.sv
// Collects els_p serial words, presents them together once all have arrived.
module bsg_serial_in_parallel_out_full #(
  parameter int unsigned width_p = 64,
  parameter int unsigned els_p   = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       v_i,
  input  logic [width_p-1:0]         data_i,
  output logic                       ready_o,
  output logic                       v_o,
  output logic [els_p*width_p-1:0]   data_o,
  input  logic                       yumi_i
);

  localparam int unsigned idx_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam logic [idx_w_lp-1:0] last_lp = idx_w_lp'(els_p - 1);

  logic [idx_w_lp-1:0]           idx_q, idx_d;
  logic                          full_q, full_d;
  logic [els_p-1:0][width_p-1:0] data_q, data_d;
  logic                          take;

  // Fill pointer and full flag; a full buffer refuses input until yumi
  always_comb begin
    take   = v_i & ~full_q;
    idx_d  = idx_q;
    full_d = full_q;
    data_d = data_q;
    if (take) begin
      data_d[idx_q] = data_i;
      if (idx_q == last_lp) begin
        idx_d  = '0;
        full_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
    if (yumi_i) begin
      full_d = 1'b0;
    end
  end

  // Control state
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      idx_q  <= '0;
      full_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      full_q <= full_d;
    end
  end

  // Word storage, not reset
  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  assign ready_o = ~full_q;
  assign v_o     = full_q;
  assign data_o  = data_q;

endmodule

// File: rtl/bp_me_cce_mem_to_link.sv
// Serialises one full-block CCE memory command onto a dword link and
// rebuilds the memory response from the returning flits.
module bp_me_cce_mem_to_link
  import bp_me_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_inv_cfg
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i,
  input  logic                            mem_cmd_v_i,
  output logic                            mem_cmd_ready_o,
  output logic [cce_mem_msg_width_lp-1:0] mem_resp_o,
  output logic                            mem_resp_v_o,
  input  logic                            mem_resp_yumi_i,
  output logic [dword_width_p-1:0]        link_data_o,
  output logic                            link_v_o,
  input  logic                            link_ready_i,
  input  logic [dword_width_p-1:0]        link_data_i,
  input  logic                            link_v_i,
  output logic                            link_yumi_o
);

  localparam bp_proc_param_s proc_param_lp = bp_proc_param(bp_params_p);
  localparam int unsigned block_size_in_words_lp =
    proc_param_lp.cce_block_width / proc_param_lp.dword_width;
  localparam int unsigned word_cnt_width_lp =
    (block_size_in_words_lp > 1) ? $clog2(block_size_in_words_lp) : 1;
  localparam logic [word_cnt_width_lp-1:0] cnt_last_lp =
    word_cnt_width_lp'(block_size_in_words_lp - 1);

  localparam logic [2:0] s_ready     = 3'd0;
  localparam logic [2:0] s_send_hdr  = 3'd1;
  localparam logic [2:0] s_send_data = 3'd2;
  localparam logic [2:0] s_recv      = 3'd3;
  localparam logic [2:0] s_resp      = 3'd4;

  logic [2:0]                   state_q, state_d;
  bp_cce_mem_msg_s              cmd_in, cmd_q, cmd_d, resp;
  bp_me_link_hdr_s              link_hdr;
  logic [block_size_in_words_lp-1:0][dword_width_p-1:0] cmd_words;
  logic [word_cnt_width_lp-1:0] cnt;
  logic                         cnt_clear, cnt_up, cnt_last, is_wr, rd_take;
  logic                         sipo_v_li, sipo_ready_lo, sipo_v_lo, sipo_yumi_li;
  logic [cce_block_width_p-1:0] sipo_data_lo;

  assign cmd_in    = mem_cmd_i;
  assign is_wr     = (cmd_q.msg_type == e_cce_mem_wr);
  assign cmd_words = cmd_q.data;
  assign cnt_last  = (cnt == cnt_last_lp);

  bsg_counter_clear_up #(
    .max_val_p(block_size_in_words_lp - 1),
    .width_p  (word_cnt_width_lp)
  ) word_counter (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear_i(cnt_clear),
    .up_i   (cnt_up),
    .count_o(cnt)
  );

  bsg_serial_in_parallel_out_full #(
    .width_p(dword_width_p),
    .els_p  (block_size_in_words_lp)
  ) read_sipo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (sipo_v_li),
    .data_i (link_data_i),
    .ready_o(sipo_ready_lo),
    .v_o    (sipo_v_lo),
    .data_o (sipo_data_lo),
    .yumi_i (sipo_yumi_li)
  );

  // Command latch: captured only on acceptance
  always_comb begin
    cmd_d = cmd_q;
    if ((state_q == s_ready) && mem_cmd_v_i) begin
      cmd_d = cmd_in;
    end
  end

  // Header flit and response assembly from the latched command
  always_comb begin
    link_hdr       = '0;
    link_hdr.write = is_wr;
    link_hdr.addr  = cmd_q.addr;
    resp           = cmd_q;
    resp.data      = is_wr ? '0 : sipo_data_lo;
  end

  // Link FSM: next state, handshakes and counter control
  always_comb begin
    state_d         = state_q;
    cnt_clear       = 1'b0;
    cnt_up          = 1'b0;
    rd_take         = 1'b0;
    mem_cmd_ready_o = 1'b0;
    mem_resp_v_o    = 1'b0;
    link_v_o        = 1'b0;
    link_data_o     = '0;
    link_yumi_o     = 1'b0;
    sipo_v_li       = 1'b0;
    sipo_yumi_li    = 1'b0;
    case (state_q)
      s_ready: begin
        mem_cmd_ready_o = 1'b1;
        if (mem_cmd_v_i) state_d = s_send_hdr;
      end
      s_send_hdr: begin
        link_v_o    = 1'b1;
        link_data_o = link_hdr;
        if (link_ready_i) state_d = is_wr ? s_send_data : s_recv;
      end
      s_send_data: begin
        link_v_o    = 1'b1;
        link_data_o = cmd_words[cnt];
        if (link_ready_i) begin
          if (cnt_last) begin
            cnt_clear = 1'b1;
            state_d   = s_recv;
          end else begin
            cnt_up = 1'b1;
          end
        end
      end
      s_recv: begin
        if (is_wr) begin
          link_yumi_o = link_v_i;
          if (link_v_i) state_d = s_resp;
        end else begin
          rd_take     = link_v_i & sipo_ready_lo;
          sipo_v_li   = link_v_i;
          link_yumi_o = rd_take;
          if (rd_take) begin
            if (cnt_last) begin
              cnt_clear = 1'b1;
              state_d   = s_resp;
            end else begin
              cnt_up = 1'b1;
            end
          end
        end
      end
      s_resp: begin
        mem_resp_v_o = 1'b1;
        if (mem_resp_yumi_i) begin
          sipo_yumi_li = ~is_wr;
          state_d      = s_ready;
        end
      end
      default: state_d = s_ready;
    endcase
  end

  assign mem_resp_o = resp;

  // FSM state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= s_ready;
    end else begin
      state_q <= state_d;
    end
  end

  // Latched command, deliberately not reset
  always_ff @(posedge clk_i) begin
    cmd_q <= cmd_d;
  end

`ifndef SYNTHESIS
  a_full_block: assert property (@(posedge clk_i) disable iff (reset_i)
    (mem_cmd_v_i && mem_cmd_ready_o) |-> (cmd_in.size == e_mem_msg_size_64))
    else $error("bp_me_cce_mem_to_link: only full-block commands are supported");
  a_msg_type: assert property (@(posedge clk_i) disable iff (reset_i)
    (mem_cmd_v_i && mem_cmd_ready_o) |->
      (cmd_in.msg_type inside {e_cce_mem_rd, e_cce_mem_wr}))
    else $error("bp_me_cce_mem_to_link: unsupported msg_type");
  a_rd_complete: assert property (@(posedge clk_i) disable iff (reset_i)
    ((state_q == s_resp) && !is_wr) |-> sipo_v_lo)
    else $error("bp_me_cce_mem_to_link: read response without a full block");
`endif

endmodule

// File: tb/tb_bp_me_cce_mem_to_link.sv
// Directed bench for the CCE memory-message to link serialiser.
module tb_bp_me_cce_mem_to_link;
  import bp_me_pkg::*;

  localparam int unsigned N  = cce_block_width_p / dword_width_p;
  localparam int unsigned MW = cce_mem_msg_width_lp;

  logic clk, reset_i;
  logic [MW-1:0] mem_cmd_i, mem_resp_o;
  logic mem_cmd_v_i, mem_cmd_ready_o, mem_resp_v_o, mem_resp_yumi_i;
  logic [63:0] link_data_o, link_data_i;
  logic link_v_o, link_ready_i, link_v_i, link_yumi_o;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  bp_me_cce_mem_to_link #(.bp_params_p(e_bp_inv_cfg)) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .mem_cmd_i      (mem_cmd_i),
    .mem_cmd_v_i    (mem_cmd_v_i),
    .mem_cmd_ready_o(mem_cmd_ready_o),
    .mem_resp_o     (mem_resp_o),
    .mem_resp_v_o   (mem_resp_v_o),
    .mem_resp_yumi_i(mem_resp_yumi_i),
    .link_data_o    (link_data_o),
    .link_v_o       (link_v_o),
    .link_ready_i   (link_ready_i),
    .link_data_i    (link_data_i),
    .link_v_i       (link_v_i),
    .link_yumi_o    (link_yumi_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        wr;
    logic [39:0] addr;
    logic [63:0] base;     // write data word i / returned read word i = base+i
    logic        stall;    // link_ready_i toggles starting low
    logic        stray;    // link_v_i held high while idle/sending
    logic        gap;      // inbound valid only every other cycle
    int unsigned hold;     // cycles mem_resp_yumi_i stays low
    logic [63:0] exp_hdr;  // hand-computed header flit
  } vec_s;

  vec_s vecs [5];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: actual %0h required %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: actual %0h required %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic chkm(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: actual %0h required %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic bp_cce_mem_msg_s mk_cmd(input vec_s v);
    bp_cce_mem_msg_s m;
    m = '0;
    m.msg_type       = v.wr ? e_cce_mem_wr : e_cce_mem_rd;
    m.addr           = v.addr;
    m.size           = e_mem_msg_size_64;
    m.payload.lce_id = 4'h5;
    m.payload.way_id = 3'h3;
    for (int unsigned i = 0; i < N; i++)
      m.data[i*64 +: 64] = v.wr ? v.base + 64'(i) : 64'hC0DE_0000 + 64'(i);
    return m;
  endfunction

  task automatic run_txn(input int unsigned id, input vec_s v);
    bp_cce_mem_msg_s c, e;
    int unsigned n, k, cyc, cyc_last, exp_n, exp_r;
    logic tog, have_prev, stray_bad, yumi_bad;
    logic [63:0] prev, exp_flit;
    c = mk_cmd(v);
    e = c;
    for (int unsigned i = 0; i < N; i++)
      e.data[i*64 +: 64] = v.wr ? 64'h0 : v.base + 64'(i);
    exp_n = v.wr ? N + 1 : 1;
    exp_r = v.wr ? 1 : N;
    // offer the command (cycle 0)
    @(negedge clk);
    mem_cmd_i = c; mem_cmd_v_i = 1'b1; link_v_i = v.stray; link_data_i = 64'hBAD0;
    #1;
    chk1($sformatf("v%0d_cmd_ready", id), mem_cmd_ready_o, 1'b1);
    chk1($sformatf("v%0d_idle_yumi", id), link_yumi_o, 1'b0);
    // outbound flits
    n = 0; cyc = 0; cyc_last = 0; tog = 1'b0; have_prev = 1'b0; stray_bad = 1'b0;
    prev = '0;
    while (n < exp_n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      mem_cmd_v_i = 1'b0;
      link_ready_i = v.stall ? tog : 1'b1;
      tog = ~tog;
      #1;
      if (link_yumi_o) stray_bad = 1'b1;
      if (link_v_o) begin
        if (have_prev) chk64($sformatf("v%0d_stall_hold", id), link_data_o, prev);
        if (link_ready_i) begin
          exp_flit = (n == 0) ? v.exp_hdr : v.base + 64'(n - 1);
          chk64($sformatf("v%0d_flit%0d", id, n), link_data_o, exp_flit);
          n++;
          cyc_last = cyc;
          have_prev = 1'b0;
        end else begin
          prev = link_data_o;
          have_prev = 1'b1;
        end
      end
    end
    chk64($sformatf("v%0d_handshakes", id), 64'(n), 64'(exp_n));
    chk1($sformatf("v%0d_send_yumi", id), stray_bad, 1'b0);
    if (!v.stall) chk64($sformatf("v%0d_send_cycles", id), 64'(cyc_last), 64'(exp_n));
    // inbound flits
    k = 0; cyc = 0; yumi_bad = 1'b0;
    while (k < exp_r && cyc < 200) begin
      @(negedge clk);
      link_ready_i = 1'b0;
      link_v_i = !(v.gap && cyc[0]);
      link_data_i = v.wr ? 64'h0ACC : v.base + 64'(k);
      #1;
      if (link_yumi_o !== link_v_i) yumi_bad = 1'b1;
      if (link_v_i && link_yumi_o) k++;
      cyc++;
    end
    chk64($sformatf("v%0d_recv_count", id), 64'(k), 64'(exp_r));
    chk1($sformatf("v%0d_recv_yumi", id), yumi_bad, 1'b0);
    // response: valid the cycle after the last inbound flit
    @(negedge clk);
    link_v_i = 1'b1; link_data_i = 64'hBAD1; mem_resp_yumi_i = 1'b0;
    #1;
    chk1($sformatf("v%0d_resp_v", id), mem_resp_v_o, 1'b1);
    chkm($sformatf("v%0d_resp", id), mem_resp_o, e);
    chk1($sformatf("v%0d_resp_stray_yumi", id), link_yumi_o, 1'b0);
    for (int unsigned h = 0; h < v.hold; h++) begin
      @(negedge clk);
      link_v_i = 1'b0;
      #1;
      chkm($sformatf("v%0d_resp_hold%0d", id, h), mem_resp_o, e);
      chk1($sformatf("v%0d_hold_v%0d", id, h), mem_resp_v_o, 1'b1);
      chk1($sformatf("v%0d_hold_ready%0d", id, h), mem_cmd_ready_o, 1'b0);
    end
    @(negedge clk);
    link_v_i = 1'b0; mem_resp_yumi_i = 1'b1;
    #1;
    chkm($sformatf("v%0d_resp_at_yumi", id), mem_resp_o, e);
    @(negedge clk);
    mem_resp_yumi_i = 1'b0;
    #1;
    chk1($sformatf("v%0d_post_ready", id), mem_cmd_ready_o, 1'b1);
    chk1($sformatf("v%0d_post_resp_v", id), mem_resp_v_o, 1'b0);
  endtask

  // Abort a transaction with reset after three words have moved
  task automatic reset_mid(input logic wr);
    vec_s v;
    v = '{wr, 40'h00_8000_0200, 64'h50, 1'b0, 1'b0, 1'b0, 0, 64'h0};
    @(negedge clk);
    mem_cmd_i = mk_cmd(v); mem_cmd_v_i = 1'b1; link_ready_i = 1'b1; link_v_i = 1'b0;
    @(negedge clk);
    mem_cmd_v_i = 1'b0;
    for (int unsigned w = 0; w < 3; w++) begin
      @(negedge clk);
      link_v_i = !wr; link_data_i = 64'h50 + 64'(w);
    end
    @(negedge clk);
    link_v_i = !wr; link_data_i = 64'h53;
    #1;
    chk1(wr ? "rstw_busy_link_v" : "rstr_busy_yumi", wr ? link_v_o : link_yumi_o, 1'b1);
    reset_i = 1'b1;
    #1;
    chk1(wr ? "rstw_resp_v" : "rstr_resp_v", mem_resp_v_o, 1'b0);
    chk1(wr ? "rstw_link_v" : "rstr_link_v", link_v_o, 1'b0);
    chk1(wr ? "rstw_yumi" : "rstr_yumi", link_yumi_o, 1'b0);
    @(negedge clk);
    link_v_i = 1'b0; link_ready_i = 1'b0;
    reset_i = 1'b0;
    #1;
    chk1(wr ? "rstw_cmd_ready" : "rstr_cmd_ready", mem_cmd_ready_o, 1'b1);
  endtask

  initial begin
    //         wr    addr               base                    stall stray gap  hold hdr
    vecs[0] = '{1'b0, 40'h00_8000_0040, 64'h0,                  1'b0, 1'b1, 1'b0, 0, 64'h0000_0000_8000_0040};
    vecs[1] = '{1'b1, 40'h00_8000_0080, 64'hA0,                 1'b0, 1'b0, 1'b0, 0, 64'h0000_0100_8000_0080};
    vecs[2] = '{1'b1, 40'h00_8000_00C0, 64'hB0,                 1'b1, 1'b1, 1'b0, 0, 64'h0000_0100_8000_00C0};
    vecs[3] = '{1'b0, 40'h00_1234_5600, 64'h100,                1'b0, 1'b0, 1'b0, 5, 64'h0000_0000_1234_5600};
    vecs[4] = '{1'b0, 40'hFF_FFFF_FFC0, 64'hFFFF_0000_0000_0000, 1'b1, 1'b0, 1'b1, 2, 64'h0000_00FF_FFFF_FFC0};

    reset_i = 1'b0; mem_cmd_i = '0; mem_cmd_v_i = 1'b0; mem_resp_yumi_i = 1'b0;
    link_ready_i = 1'b0; link_data_i = '0; link_v_i = 1'b0;
    #1 reset_i = 1'b1;
    #2;
    chk1("reset_resp_v", mem_resp_v_o, 1'b0);
    chk1("reset_link_v", link_v_o, 1'b0);
    chk1("reset_yumi", link_yumi_o, 1'b0);
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    #1;
    chk1("reset_cmd_ready", mem_cmd_ready_o, 1'b1);

    for (int unsigned i = 0; i < 5; i++) run_txn(i, vecs[i]);

    reset_mid(1'b0);
    run_txn(10, vecs[0]);
    reset_mid(1'b1);
    run_txn(11, vecs[1]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bp_me_cce_mem_to_link.md
# bp_me_cce_mem_to_link

Downstream neighbour of the cache-DMA-to-CCE converter. It accepts full-block CCE memory commands (`mem_cmd`) and serialises each one onto a dword-wide flit link toward the off-chip memory controller. It collects the controller's reply flits and returns a CCE memory response (`mem_resp`). One transaction is outstanding at a time.

## Interface
Parameters:
- `bp_params_p`, default `e_bp_inv_cfg`: processor config; supplies `paddr_width_p`, `cce_block_width_p`, `dword_width_p`, `lce_id_width_p`, `lce_assoc_p`.
- `block_size_in_words_lp` (localparam), `cce_block_width_p/dword_width_p`: N, 8 in default config.
- `word_cnt_width_lp` (localparam), `BSG_SAFE_CLOG2(N)`.

Ports:
- `clk_i` in 1: single clock.
- `reset_i` in 1: reset, asynchronous, active-high.
- `mem_cmd_i` in `cce_mem_msg_width_lp`: `bp_cce_mem_msg_s` command.
- `mem_cmd_v_i` in 1: command valid.
- `mem_cmd_ready_o` out 1: command accepted when `v&ready`.
- `mem_resp_o` out `cce_mem_msg_width_lp`: `bp_cce_mem_msg_s` response.
- `mem_resp_v_o` out 1: response valid.
- `mem_resp_yumi_i` in 1: response consumed.
- `link_data_o` out `dword_width_p`: outbound flit.
- `link_v_o` out 1: outbound valid.
- `link_ready_i` in 1: outbound transfer when `v&ready`.
- `link_data_i` in `dword_width_p`: inbound flit.
- `link_v_i` in 1: inbound valid.
- `link_yumi_o` out 1: inbound flit consumed.

## Operation
- States: `READY`, `SEND_HDR`, `SEND_DATA`, `RECV`, `RESP`.
- `READY`:
  - `mem_cmd_ready_o=1`.
  - On `mem_cmd_v_i`, latch the whole command header plus data and go to `SEND_HDR`.
- `SEND_HDR`:
  - `link_v_o=1`.
  - Header flit is `bp_me_link_hdr_s`: bit[`paddr_width_p`] = write (`msg_type==e_cce_mem_wr`), bits[`paddr_width_p-1:0`] = addr, upper bits zero.
  - On `link_ready_i`, go to `SEND_DATA` if write, else `RECV`.
- `SEND_DATA`:
  - `link_v_o=1`; `link_data_o` is data word `cnt` (word 0 = bits[63:0]).
  - Each handshake increments `cnt`.
  - At `cnt==N-1` with handshake: `cnt←0`, go to `RECV`.
- `RECV`:
  - `link_yumi_o=link_v_i`.
  - Read: flit `cnt` is written into `data_r[cnt]`; after word N-1, `cnt←0` and go to `RESP`.
  - Write: exactly one ack flit is consumed (value ignored), then go to `RESP`.
- `RESP`:
  - `mem_resp_v_o=1`.
  - Header equals the latched command header (msg_type, addr, payload, size).
  - Data is `data_r` for reads and `'0` for writes.
  - On `mem_resp_yumi_i`, go to `READY`.
- `link_yumi_o=0` outside `RECV`; stray inbound flits are left unconsumed.
- Only `e_mem_msg_size_64` (full block) is supported. Any other size still moves a full block; simulation asserts an error.
- `msg_type` other than `e_cce_mem_rd`/`e_cce_mem_wr` triggers a simulation assertion.

## Timing
- Reset (asynchronous, immediate):
  - state←`READY`, `cnt`←0.
  - `mem_resp_v_o=0`, `link_v_o=0`, `link_yumi_o=0`, `mem_cmd_ready_o=1` after reset deasserts.
  - Latched data registers are not reset.
- Reset mid-transaction aborts it with no response; the link partner must be reset concurrently.
- Read, with no stalls:
  - cmd accepted cycle 0; header flit cycle 1.
  - Inbound words are accepted the same cycle they are valid.
  - `mem_resp_v_o` is high the cycle after the last word is consumed.
- Write, with no stalls:
  - header cycle 1, data cycles 2..N+1, ack ≥ cycle N+2.
  - resp the cycle after the ack.
- Stall rules:
  - `link_data_o` is held stable while `link_v_o & ~link_ready_i`.
  - `mem_resp_o` is held stable until yumi.
- No bypass: at least one idle `READY` cycle separates consecutive commands. The cycle after a response is consumed is `READY`.
- `cnt` is `word_cnt_width_lp` bits and wraps to 0 only by explicit clear at N-1.

## Structure
- `bp_me_link_hdr_s` (write bit, addr, pad to `dword_width_p`) belongs in `bp_me_pkg`.
- The link state enum stays local to the module.
- Uses `bsg_counter_clear_up` (max N-1) for `cnt`.
- One natural sub-module: `bsg_serial_in_parallel_out_full` for read reassembly (els N, width `dword_width_p`). Its yumi is driven by the `RESP` handshake.

## Test plan
- Read, addr `0x8000_0040`:
  - Stimulus: link returns words `0x0..0x7`.
  - Response: header flit `0x8000_0040` (write bit 0); `mem_resp` msg_type `e_cce_mem_rd`, addr `0x8000_0040`, data word i = i.
- Write, addr `0x8000_0080`, data word i = `0xA0+i`:
  - Stimulus: one ack flit.
  - Response: header has the write bit set, then flits `0xA0..0xA7`, then `mem_resp` `e_cce_mem_wr` with data 0.
- Back-pressure:
  - Stimulus: `link_ready_i` toggles 1/0 during a write.
  - Response: flit order and values unchanged; `link_data_o` stable during stalls; total of 9 handshakes.
- Response hold:
  - Stimulus: `mem_resp_yumi_i` low for 5 cycles.
  - Response: `mem_resp_o` stable; `mem_cmd_ready_o=0` until yumi, then 1 the next cycle.
- Stray inbound:
  - Stimulus: `link_v_i=1` while in `READY`/`SEND_HDR`.
  - Response: `link_yumi_o=0`.
- Reset mid-transaction:
  - Stimulus: `reset_i` asserted during read word 3.
  - Response: `mem_resp_v_o` and `link_v_o` go to 0 immediately. After release, a new read completes correctly with `cnt` starting at 0.
